// File: rtl/writeback_unit.sv
// Commit stage for execution results: register writes, single stores and
// multi-byte stack pushes, ending in a one-cycle instruction_done pulse.
module writeback_unit #(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = ADDR_WIDTH'(16'h0100),
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                     phi1,
  input  logic                     reset_n,
  input  logic                     wb_start,
  input  logic [1:0]               wb_kind,
  input  logic [SEL_WIDTH-1:0]     wb_dest,
  input  logic [ADDR_WIDTH-1:0]    wb_addr,
  input  logic [REG_WIDTH-1:0]     wb_data,
  input  logic [1:0]               push_count,
  input  logic [3*REG_WIDTH-1:0]   push_bytes,
  input  logic [REG_WIDTH-1:0]     sp_in,
  output logic                     busy,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [REG_WIDTH-1:0]     mem_data,
  output logic                     reg_we,
  output logic [SEL_WIDTH-1:0]     reg_sel,
  output logic [REG_WIDTH-1:0]     reg_data,
  output logic                     sp_we,
  output logic [REG_WIDTH-1:0]     sp_out,
  output logic                     instruction_done
);

  localparam logic [1:0] KIND_DONE = 2'd0;
  localparam logic [1:0] KIND_REG  = 2'd1;
  localparam logic [1:0] KIND_MEM  = 2'd2;
  localparam logic [1:0] KIND_PUSH = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REG  = 3'd1,
    S_MEM  = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state;
  logic [SEL_WIDTH-1:0]    dest_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [REG_WIDTH-1:0]    data_q;
  logic [3*REG_WIDTH-1:0]  bytes_q;
  logic [1:0]              rem_q;
  logic [REG_WIDTH-1:0]    sp_cur_q;
  logic                    sp_upd_q;
  logic [REG_WIDTH-1:0]    cur_byte_c;

  // Remaining-byte count selects the next byte, so the highest used byte goes first.
  always_comb begin
    cur_byte_c = bytes_q[REG_WIDTH-1:0];
    case (rem_q)
      2'd3:    cur_byte_c = bytes_q[3*REG_WIDTH-1 -: REG_WIDTH];
      2'd2:    cur_byte_c = bytes_q[2*REG_WIDTH-1 -: REG_WIDTH];
      default: cur_byte_c = bytes_q[REG_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_data         <= '0;
      reg_we           <= 1'b0;
      reg_sel          <= '0;
      reg_data         <= '0;
      sp_we            <= 1'b0;
      sp_out           <= '0;
      instruction_done <= 1'b0;
      dest_q           <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      bytes_q          <= '0;
      rem_q            <= 2'd0;
      sp_cur_q         <= '0;
      sp_upd_q         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      mem_we           <= 1'b0;
      reg_we           <= 1'b0;
      sp_we            <= 1'b0;
      instruction_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (wb_start) begin
            dest_q   <= wb_dest;
            addr_q   <= wb_addr;
            data_q   <= wb_data;
            bytes_q  <= push_bytes;
            rem_q    <= push_count;
            sp_cur_q <= sp_in;
            sp_upd_q <= 1'b0;
            busy     <= 1'b1;
            case (wb_kind)
              KIND_DONE: state <= S_DONE;
              KIND_REG:  state <= S_REG;
              KIND_MEM:  state <= S_MEM;
              KIND_PUSH: begin
                if (push_count == 2'd0) begin
                  state <= S_DONE;
                end else begin
                  state    <= S_PUSH;
                  sp_upd_q <= 1'b1;
                end
              end
              default:   state <= S_DONE;
            endcase
          end
        end

        S_REG: begin
          reg_we   <= 1'b1;
          reg_sel  <= dest_q;
          reg_data <= data_q;
          state    <= S_DONE;
        end

        S_MEM: begin
          mem_we   <= 1'b1;
          mem_addr <= addr_q;
          mem_data <= data_q;
          state    <= S_DONE;
        end

        // The stack stays inside its page: SP wraps, the page base does not move.
        S_PUSH: begin
          mem_we   <= 1'b1;
          mem_addr <= STACK_BASE + ADDR_WIDTH'(sp_cur_q);
          mem_data <= cur_byte_c;
          sp_cur_q <= sp_cur_q - REG_WIDTH'(1);
          rem_q    <= rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          instruction_done <= 1'b1;
          busy             <= 1'b0;
          if (sp_upd_q) begin
            sp_we  <= 1'b1;
            sp_out <= sp_cur_q;
          end
          sp_upd_q <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: vector table plus scoreboard of expected strobes,
// with hand-written sequences for mid-push reset and ignored restarts.
module tb_writeback_unit;

  localparam logic [3:0] SEL_X = 4'd2;

  logic        phi1 = 1'b0;
  logic        reset_n;
  logic        wb_start;
  logic [1:0]  wb_kind;
  logic [3:0]  wb_dest;
  logic [15:0] wb_addr;
  logic [7:0]  wb_data;
  logic [1:0]  push_count;
  logic [23:0] push_bytes;
  logic [7:0]  sp_in;
  logic        busy, mem_we, reg_we, sp_we, instruction_done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, reg_data, sp_out;
  logic [3:0]  reg_sel;

  writeback_unit dut (
    .phi1(phi1), .reset_n(reset_n), .wb_start(wb_start), .wb_kind(wb_kind),
    .wb_dest(wb_dest), .wb_addr(wb_addr), .wb_data(wb_data),
    .push_count(push_count), .push_bytes(push_bytes), .sp_in(sp_in),
    .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_data(reg_data),
    .sp_we(sp_we), .sp_out(sp_out), .instruction_done(instruction_done)
  );

  always #5 phi1 = ~phi1;

  // typ: 0 = memory write, 1 = register write, 2 = done pulse
  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        spwe;
  } ev_t;

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  dest;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  pc;
    logic [23:0] pb;
    logic [7:0]  sp;
    int          lat;
    logic        spwe;
    logic [7:0]  spout;
  } vec_t;

  ev_t  q[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [1:0] typ, input logic [15:0] addr,
                         input logic [7:0] data, input logic spwe);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event addr=%h data=%h, nothing expected", name, addr, data);
    end else begin
      e = q.pop_front();
      if (e.typ != typ) begin
        errors++;
        $display("FAIL %s: got event type %0d expected type %0d", name, typ, e.typ);
      end else if (typ == 2'd2) begin
        if (spwe !== e.spwe || (e.spwe && addr[7:0] !== e.addr[7:0])) begin
          errors++;
          $display("FAIL %s: got sp_we=%b sp_out=%h expected sp_we=%b sp_out=%h",
                   name, spwe, addr[7:0], e.spwe, e.addr[7:0]);
        end
      end else if (addr !== e.addr || data !== e.data) begin
        errors++;
        $display("FAIL %s: got addr/sel=%h data=%h expected addr/sel=%h data=%h",
                 name, addr, data, e.addr, e.data);
      end
    end
  endtask

  task automatic monitor();
    if (mon_en && reset_n) begin
      if (mem_we || reg_we) chk("strobe_exclusive", 32'(mem_we && reg_we), 32'd0);
      if (mem_we) pop_cmp("mem_write", 2'd0, mem_addr, mem_data, 1'b0);
      if (reg_we) pop_cmp("reg_write", 2'd1, 16'(reg_sel), reg_data, 1'b0);
      if (instruction_done) pop_cmp("done_sp", 2'd2, 16'(sp_out), 8'd0, sp_we);
      else if (sp_we) chk("sp_we_outside_done", 32'(sp_we), 32'd0);
    end
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic tick();
    @(posedge phi1);
    @(negedge phi1);
    monitor();
  endtask

  task automatic run_vec(input vec_t v, input bit hammer);
    logic [7:0] sp;
    int lat;
    bit got;
    wb_kind = v.kind; wb_dest = v.dest; wb_addr = v.addr; wb_data = v.data;
    push_count = v.pc; push_bytes = v.pb; sp_in = v.sp; wb_start = 1'b1;
    case (v.kind)
      2'd1: q.push_back('{2'd1, 16'(v.dest), v.data, 1'b0});
      2'd2: q.push_back('{2'd0, v.addr, v.data, 1'b0});
      2'd3: begin
        sp = v.sp;
        for (int i = int'(v.pc) - 1; i >= 0; i--) begin
          q.push_back('{2'd0, 16'h0100 + 16'(sp), v.pb[i*8 +: 8], 1'b0});
          sp = sp - 8'd1;
        end
      end
      default: ;
    endcase
    q.push_back('{2'd2, 16'(v.spout), 8'd0, v.spwe});
    tick();
    if (hammer) begin
      wb_kind = 2'd2; wb_addr = 16'h0300; wb_data = 8'hEE; push_count = 2'd3; sp_in = 8'h10;
    end else begin
      wb_start = 1'b0;
    end
    chk("busy_after_start", 32'(busy), 32'd1);
    got = 1'b0;
    lat = 0;
    for (int j = 1; j <= 10 && !got; j++) begin
      tick();
      if (instruction_done) begin
        got = 1'b1;
        lat = j;
      end
    end
    wb_start = 1'b0;
    chk("done_latency", 32'(lat), 32'(v.lat));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    bit quiet;
    vecs[0] = '{2'd1, SEL_X, 16'h0000, 8'h5A, 2'd0, 24'h000000, 8'h00, 2, 1'b0, 8'h00};
    vecs[1] = '{2'd2, 4'd0,  16'h0200, 8'hC3, 2'd0, 24'h000000, 8'h00, 2, 1'b0, 8'h00};
    vecs[2] = '{2'd3, 4'd0,  16'h0000, 8'h00, 2'd2, 24'h771234, 8'hFD, 3, 1'b1, 8'hFB};
    vecs[3] = '{2'd3, 4'd0,  16'h0000, 8'h00, 2'd3, 24'hABCDEF, 8'h01, 4, 1'b1, 8'hFE};
    vecs[4] = '{2'd3, 4'd0,  16'h0000, 8'h00, 2'd0, 24'h112233, 8'h40, 1, 1'b0, 8'h00};
    vecs[5] = '{2'd0, 4'd0,  16'h0000, 8'h00, 2'd0, 24'h000000, 8'h00, 1, 1'b0, 8'h00};
    vecs[6] = '{2'd3, 4'd0,  16'h0000, 8'h00, 2'd1, 24'h445599, 8'h00, 2, 1'b1, 8'hFF};
    vecs[7] = '{2'd1, 4'hF,  16'h0000, 8'h00, 2'd0, 24'h000000, 8'h00, 2, 1'b0, 8'h00};

    reset_n = 1'b0; wb_start = 1'b0; wb_kind = 2'd0; wb_dest = 4'd0; wb_addr = 16'h0;
    wb_data = 8'h0; push_count = 2'd0; push_bytes = 24'h0; sp_in = 8'h0;
    @(negedge phi1);
    tick();
    tick();
    chk("reset_strobes", 32'({busy, mem_we, reg_we, sp_we, instruction_done}), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_data", 32'({mem_data, reg_data, sp_out}), 32'd0);
    chk("reset_reg_sel", 32'(reg_sel), 32'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Back-to-back: each vector starts on the cycle its predecessor's done is seen.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

    // Starts held high throughout a push must not disturb or queue behind it.
    run_vec(vecs[3], 1'b1);
    tick(); tick(); tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    // Reset in the middle of a 3-byte push aborts it silently.
    mon_en = 1'b0;
    wb_kind = 2'd3; push_count = 2'd3; push_bytes = 24'hA1B2C3; sp_in = 8'hF0; wb_start = 1'b1;
    tick();
    wb_start = 1'b0;
    tick();
    chk("mid_push_first_write", 32'({mem_we, mem_addr, mem_data}), 32'({1'b1, 16'h01F0, 8'hA1}));
    reset_n = 1'b0;
    tick();
    chk("mid_reset_strobes", 32'({busy, mem_we, reg_we, sp_we, instruction_done}), 32'd0);
    chk("mid_reset_regs", 32'({mem_addr, mem_data}), 32'd0);
    tick();
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (mem_we || instruction_done || busy) quiet = 1'b0;
    end
    chk("no_activity_after_reset", 32'(quiet), 32'd1);

    // The unit must recover fully after the abort.
    mon_en = 1'b1;
    run_vec(vecs[2], 1'b0);
    tick();
    chk("scoreboard_final", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
